alu_selftest_ctrl: RTL

//   Built-in self-test initiator for the 8-bit ALU (ADD/SUB/AND/OR, 2-bit opcode).

---
 rtl/alu_selftest_ctrl_if.sv | 45 ++++
 rtl/alu_selftest_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_selftest_ctrl_if.sv
// Handshake/status bundle between the ALU self-test controller and its host.
// Signal prefixes are from the controller's point of view.
interface alu_selftest_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_alu_result;
  logic [WIDTH-1:0] o_alu_a;
  logic [WIDTH-1:0] o_alu_b;
  logic [1:0]       o_alu_opcode;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic [15:0]      o_err_count;
  logic [15:0]      o_first_err_vec;
  logic             o_first_err_valid;

  modport master (
    output i_start,
    output i_alu_result,
    input  o_alu_a,
    input  o_alu_b,
    input  o_alu_opcode,
    input  o_busy,
    input  o_done,
    input  o_pass,
    input  o_err_count,
    input  o_first_err_vec,
    input  o_first_err_valid
  );

  modport slave (
    input  i_start,
    input  i_alu_result,
    output o_alu_a,
    output o_alu_b,
    output o_alu_opcode,
    output o_busy,
    output o_done,
    output o_pass,
    output o_err_count,
    output o_first_err_vec,
    output o_first_err_valid
  );
endinterface

// File: rtl/alu_selftest_ctrl.sv
// Built-in self-test initiator for a 4-op ALU: drives LFSR operands with a cycling
// opcode, checks each result against a local reference and reports pass/fail status.
module alu_selftest_ctrl #(
  parameter int          WIDTH       = 8,
  parameter int          NUM_VECTORS = 256,
  parameter int          ALU_LATENCY = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hA55A
) (
  input  logic               clk,
  input  logic               rst,
  alu_selftest_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0]       OP_ADD   = 2'b00;
  localparam logic [1:0]       OP_SUB   = 2'b01;
  localparam logic [1:0]       OP_AND   = 2'b10;
  localparam logic [1:0]       OP_OR    = 2'b11;
  localparam int               LAT_W    = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = (ALU_LATENCY > 0) ? LAT_W'(ALU_LATENCY - 1) : '0;
  localparam logic [15:0]      LAST_VEC = 16'(NUM_VECTORS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_lfsr;
  logic [15:0]      r_vec_idx;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_opcode;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_err_count;
  logic [15:0]      r_first_err_vec;
  logic             r_first_err_valid;

  logic             w_lfsr_fb;
  logic [15:0]      w_lfsr_nxt;
  logic [WIDTH-1:0] w_expected;
  logic             w_mismatch;
  logic             w_last_vec;
  logic             w_start_ok;

  // Fibonacci LFSR, taps 16/14/13/11, shifting left with feedback into bit 0
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_nxt = {r_lfsr[14:0], w_lfsr_fb};
  assign w_last_vec = (r_vec_idx == LAST_VEC);
  assign w_start_ok = bus.i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_mismatch = (bus.i_alu_result != w_expected);

  always_comb begin
    w_expected = '0;
    case (r_alu_opcode)
      OP_ADD:  w_expected = r_alu_a + r_alu_b;
      OP_SUB:  w_expected = r_alu_a - r_alu_b;
      OP_AND:  w_expected = r_alu_a & r_alu_b;
      OP_OR:   w_expected = r_alu_a | r_alu_b;
      default: w_expected = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_DRIVE;
      S_DRIVE: w_state_nxt = (ALU_LATENCY > 0) ? S_WAIT : S_CHECK;
      S_WAIT:  if (r_lat_cnt == '0) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_last_vec ? S_DONE : S_DRIVE;
      S_DONE:  if (w_start_ok) w_state_nxt = S_DRIVE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr            <= LFSR_SEED;
      r_vec_idx         <= '0;
      r_lat_cnt         <= '0;
      r_alu_a           <= '0;
      r_alu_b           <= '0;
      r_alu_opcode      <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_count       <= '0;
      r_first_err_vec   <= '0;
      r_first_err_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_lfsr            <= LFSR_SEED;
            r_vec_idx         <= '0;
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_alu_a      <= WIDTH'(r_lfsr[15:8]);
          r_alu_b      <= WIDTH'(r_lfsr[7:0]);
          r_alu_opcode <= r_vec_idx[1:0];
          r_lat_cnt    <= LAT_LOAD;
        end
        S_WAIT: begin
          if (r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - 1'b1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            if (!r_first_err_valid) begin
              r_first_err_vec   <= r_vec_idx;
              r_first_err_valid <= 1'b1;
            end
          end
          if (w_last_vec) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            // Verdict must include this final comparison, not just the registered count
            r_pass <= !w_mismatch && (r_err_count == '0);
          end else begin
            r_vec_idx <= r_vec_idx + 16'd1;
            r_lfsr    <= w_lfsr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_alu_a           = r_alu_a;
  assign bus.o_alu_b           = r_alu_b;
  assign bus.o_alu_opcode      = r_alu_opcode;
  assign bus.o_busy            = r_busy;
  assign bus.o_done            = r_done;
  assign bus.o_pass            = r_pass;
  assign bus.o_err_count       = r_err_count;
  assign bus.o_first_err_vec   = r_first_err_vec;
  assign bus.o_first_err_valid = r_first_err_valid;

endmodule
